// File: rtl/instr_cache_pkg.sv
// Shared definitions for the direct-mapped instruction cache: geometry,
// PC field positions and controller state encoding.
package instr_cache_pkg;

    localparam int unsigned ADDR_W     = 10;
    localparam int unsigned INDEX_W    = 3;
    localparam int unsigned WORD_SEL_W = 2;
    localparam int unsigned TAG_W      = ADDR_W - INDEX_W - WORD_SEL_W - 2;

    localparam int unsigned WORD_W     = 32;
    localparam int unsigned LINES      = 1 << INDEX_W;
    localparam int unsigned WORDS      = 1 << WORD_SEL_W;
    localparam int unsigned BLOCK_W    = WORD_W * WORDS;
    localparam int unsigned BLK_ADDR_W = ADDR_W - WORD_SEL_W - 2;

    localparam int unsigned WORD_LSB   = 2;
    localparam int unsigned INDEX_LSB  = WORD_LSB + WORD_SEL_W;
    localparam int unsigned TAG_LSB    = INDEX_LSB + INDEX_W;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_MEM_READ = 2'd1,
        ST_UPDATE   = 2'd2
    } state_e;

endpackage

// File: rtl/instr_cache_if.sv
// Block-read handshake between the instruction cache (master) and
// instruction memory (slave).
interface instr_cache_if;
    import instr_cache_pkg::*;

    logic                  mem_read;
    logic [BLK_ADDR_W-1:0] mem_address;
    logic [BLOCK_W-1:0]    mem_readdata;
    logic                  mem_busywait;

    modport master (
        output mem_read,
        output mem_address,
        input  mem_readdata,
        input  mem_busywait
    );

    modport slave (
        input  mem_read,
        input  mem_address,
        output mem_readdata,
        output mem_busywait
    );

endinterface

// File: rtl/icache_ctrl_fsm.sv
// Miss-handling controller: sequences IDLE -> MEM_READ -> UPDATE and produces
// the CPU stall, the memory read request and the buffer/array write strobes.
module icache_ctrl_fsm
    import instr_cache_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic i_hit,
    input  logic i_mem_busywait,
    output logic o_mem_read,
    output logic o_busywait_c,
    output logic o_miss_c,
    output logic o_capture_c,
    output logic o_fill_c
);

    state_e r_state;
    state_e w_next_state;
    logic   r_mem_read;

    // mem_read is registered from the next state so it matches MEM_READ exactly
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_mem_read <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_mem_read <= (w_next_state == ST_MEM_READ);
        end
    end

    always_comb begin
        w_next_state = r_state;
        o_busywait_c = 1'b0;
        o_miss_c     = 1'b0;
        o_capture_c  = 1'b0;
        o_fill_c     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                o_busywait_c = !i_hit;
                if (!i_hit) begin
                    o_miss_c     = 1'b1;
                    w_next_state = ST_MEM_READ;
                end
            end
            ST_MEM_READ: begin
                o_busywait_c = 1'b1;
                if (!i_mem_busywait) begin
                    o_capture_c  = 1'b1;
                    w_next_state = ST_UPDATE;
                end
            end
            ST_UPDATE: begin
                o_busywait_c = 1'b1;
                o_fill_c     = 1'b1;
                w_next_state = ST_IDLE;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    assign o_mem_read = r_mem_read;

endmodule

// File: rtl/instr_cache.sv
// Direct-mapped instruction cache: 8 lines of 4 words, same-cycle hit path,
// single outstanding block fill from instruction memory on a miss.
module instr_cache
    import instr_cache_pkg::*;
(
    input  logic          CLK,
    input  logic          RESET,
    input  logic [31:0]   PC,
    output logic [31:0]   INSTRUCTION,
    output logic          BUSYWAIT,
    instr_cache_if.master mem
);

    logic [LINES-1:0]      r_valid;
    logic [TAG_W-1:0]      r_tag  [LINES];
    logic [BLOCK_W-1:0]    r_data [LINES];
    logic [BLOCK_W-1:0]    r_buffer;
    logic [BLK_ADDR_W-1:0] r_mem_address;

    logic [INDEX_W-1:0]             w_index;
    logic [TAG_W-1:0]               w_tag;
    logic [WORD_SEL_W-1:0]          w_word;
    logic [WORDS-1:0][WORD_W-1:0]   w_line;
    logic                           w_hit;
    logic                           w_miss;
    logic                           w_capture;
    logic                           w_fill;
    logic                           w_mem_read;
    logic [INDEX_W-1:0]             w_fill_index;
    logic [TAG_W-1:0]               w_fill_tag;
    logic                           w_unused_pc;

    assign w_index = PC[INDEX_LSB +: INDEX_W];
    assign w_tag   = PC[TAG_LSB +: TAG_W];
    assign w_word  = PC[WORD_LSB +: WORD_SEL_W];

    // Upper PC bits alias into the 1 KiB space and byte-offset bits are ignored
    assign w_unused_pc = ^{PC[31:ADDR_W], PC[WORD_LSB-1:0]};

    assign w_hit       = r_valid[w_index] && (r_tag[w_index] == w_tag);
    assign w_line      = r_data[w_index];
    assign INSTRUCTION = w_line[w_word];

    // The fill target comes from the block address latched at miss entry, not the live PC
    assign w_fill_index = r_mem_address[INDEX_W-1:0];
    assign w_fill_tag   = r_mem_address[BLK_ADDR_W-1 -: TAG_W];

    icache_ctrl_fsm u_ctrl (
        .clk            (CLK),
        .rst            (RESET),
        .i_hit          (w_hit),
        .i_mem_busywait (mem.mem_busywait),
        .o_mem_read     (w_mem_read),
        .o_busywait_c   (BUSYWAIT),
        .o_miss_c       (w_miss),
        .o_capture_c    (w_capture),
        .o_fill_c       (w_fill)
    );

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_valid       <= '0;
            r_mem_address <= '0;
        end else begin
            if (w_miss) r_mem_address <= PC[INDEX_LSB +: BLK_ADDR_W];
            if (w_fill) r_valid[w_fill_index] <= 1'b1;
        end
    end

    // Tag/data storage is not cleared by reset; reset only blocks a pending write
    always_ff @(posedge CLK) begin
        if (!RESET && w_capture) r_buffer <= mem.mem_readdata;
        if (!RESET && w_fill) begin
            r_tag[w_fill_index]  <= w_fill_tag;
            r_data[w_fill_index] <= r_buffer;
        end
    end

    assign mem.mem_read    = w_mem_read;
    assign mem.mem_address = r_mem_address;

endmodule
